// File: rtl/tff_pkg.sv
// Shared mode encoding for the T flip-flop bank.
package tff_pkg;

  typedef logic [1:0] tff_mode_t;

  localparam tff_mode_t TFF_MODE_TOGGLE = 2'd0;
  localparam tff_mode_t TFF_MODE_UP     = 2'd1;
  localparam tff_mode_t TFF_MODE_DOWN   = 2'd2;
  localparam tff_mode_t TFF_MODE_LOAD   = 2'd3;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous reset value and synchronous load path.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  // Load takes priority over toggle; both are gated by enable.
  always_comb begin
    q_d = q_q;
    if (en && ld) begin
      q_d = d;
    end else if (en && t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_bank.sv
// Bank of WIDTH T flops whose toggle network is reconfigured by mode.
// Optional build macro TFF_BANK_SAT_EN: UP/DOWN saturate at the boundary.
module tff_bank
  import tff_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  tff_mode_t        mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RstValW = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] up_pfx;
  logic [WIDTH-1:0] dn_pfx;
  logic [WIDTH-1:0] tog;
  logic             ld;
  logic             wrap_q;
  logic             wrap_d;

  // Bit i toggles when all lower bits are ones (up) or all zeros (down).
  always_comb begin
    up_pfx = '0;
    dn_pfx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic up_acc;
      logic dn_acc;
      up_acc = 1'b1;
      dn_acc = 1'b1;
      for (int j = 0; j < i; j++) begin
        up_acc = up_acc & q[j];
        dn_acc = dn_acc & ~q[j];
      end
      up_pfx[i] = up_acc;
      dn_pfx[i] = dn_acc;
    end
  end

  assign tc = ((mode == TFF_MODE_UP)   && (&q)) ||
              ((mode == TFF_MODE_DOWN) && !(|q));

  always_comb begin
    tog = '0;
    ld  = 1'b0;
    case (mode)
      TFF_MODE_TOGGLE: tog = t;
      TFF_MODE_UP:     tog = up_pfx;
      TFF_MODE_DOWN:   tog = dn_pfx;
      default:         ld  = 1'b1;
    endcase
`ifdef TFF_BANK_SAT_EN
    // At the boundary the count request is dropped rather than wrapping.
    if (tc) begin
      tog = '0;
    end
`else
`endif
  end

  assign wrap_d = en & tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RstValW[i]),
      .en      (en),
      .t       (tog[i]),
      .ld      (ld),
      .d       (load_val[i]),
      .q       (q[i])
    );
  end

endmodule
